factor_check_seq: RTL



---
 rtl/factor_check_pkg.sv | 26 ++
 rtl/factor_check_seq_mul.sv | 65 ++++++
 rtl/factor_check_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/factor_check_pkg.sv
// Shared types and helpers for the sequential factorization checker.
package factor_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned SAT_MAX_W = 64;

  // Width of the multiplier step counter: it must hold 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                   input int unsigned width);
    logic [SAT_MAX_W-1:0] max_v;
    max_v = (width >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
    return (value == max_v) ? value : value + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/factor_check_seq_mul.sv
// W-cycle shift-add multiplier; one partial product per step, no early exit.
module shift_add_mul
  import factor_check_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] acc,
  output logic           done_c
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = cnt_width(W);

  logic [PW-1:0] mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Load operands or advance one multiplier bit.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = PW'(a);
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc    = acc_q;
  // High during the step that consumes the last multiplier bit.
  assign done_c = step && (cnt_q == CW'(W - 1));

endmodule

// File: rtl/factor_check_seq.sv
// Sequential factorization checker: accepts (a, b, y), multiplies, flags the result.
module factor_check_seq
  import factor_check_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ok,
  output logic             mismatch,
  output logic             trivial,
  output logic [2*W-1:0]   prod,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] pass_cnt
);

  localparam int unsigned PW = 2 * W;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             ok_q, ok_d;
  logic             mismatch_q, mismatch_d;
  logic             trivial_q, trivial_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [PW-1:0]    y_q, y_d;
  logic             triv_lat_q, triv_lat_d;

  logic             load_c;
  logic             step_c;
  logic             mul_done_c;
  logic [PW-1:0]    acc;

  shift_add_mul #(.W(W)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .step   (step_c),
    .a      (a),
    .b      (b),
    .acc    (acc),
    .done_c (mul_done_c)
  );

  // Next-state, flag and counter logic.
  always_comb begin
    state_d    = state_q;
    load_c     = 1'b0;
    step_c     = 1'b0;
    ok_d       = ok_q;
    mismatch_d = mismatch_q;
    trivial_d  = trivial_q;
    prod_d     = prod_q;
    chk_cnt_d  = chk_cnt_q;
    pass_cnt_d = pass_cnt_q;
    y_d        = y_q;
    triv_lat_d = triv_lat_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_c     = 1'b1;
          y_d        = y;
          triv_lat_d = (a == W'(1)) || (b == W'(1));
          state_d    = MUL;
        end
      end
      MUL: begin
        step_c = 1'b1;
        if (mul_done_c) begin
          state_d = CMP;
        end
      end
      CMP: begin
        prod_d     = acc;
        mismatch_d = (acc != y_q);
        ok_d       = (acc == y_q) && !triv_lat_q;
        trivial_d  = triv_lat_q;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          chk_cnt_d = CNT_W'(sat_inc(SAT_MAX_W'(chk_cnt_q), CNT_W));
          if (ok_q) begin
            pass_cnt_d = CNT_W'(sat_inc(SAT_MAX_W'(pass_cnt_q), CNT_W));
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ok_q        <= 1'b0;
      mismatch_q  <= 1'b0;
      trivial_q   <= 1'b0;
      prod_q      <= '0;
      chk_cnt_q   <= '0;
      pass_cnt_q  <= '0;
      y_q         <= '0;
      triv_lat_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ok_q        <= ok_d;
      mismatch_q  <= mismatch_d;
      trivial_q   <= trivial_d;
      prod_q      <= prod_d;
      chk_cnt_q   <= chk_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      y_q         <= y_d;
      triv_lat_q  <= triv_lat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ok        = ok_q;
  assign mismatch  = mismatch_q;
  assign trivial   = trivial_q;
  assign prod      = prod_q;
  assign chk_cnt   = chk_cnt_q;
  assign pass_cnt  = pass_cnt_q;

endmodule
